// File: rtl/fp_mul.sv
// Multi-cycle IEEE-754 single-precision multiplier: shift-add significand
// product over ITER cycles, then one normalize/round-to-nearest-even cycle.
module fp_mul #(
    parameter int BPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    output logic        busy,
    output logic        res_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);
    localparam int ITER = 24 / BPC;

    typedef enum logic [1:0] {IDLE, MUL, RND} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [47:0] mcand_q, mcand_d, acc_q, acc_d, pp;
    logic [23:0] mplier_q, mplier_d;
    logic        res_vld_q, res_vld_d;

    // rounding / packing datapath
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb, mant;
    logic [23:0]       mant_r;
    logic              sc, guard, sticky;
    logic signed [9:0] e_raw, e_n, e_fin;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0]       res;

    always_comb begin
        pp = '0;
        for (int i = 0; i < BPC; i++)
            if (mplier_q[i]) pp = pp + (mcand_q << i);
    end

    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        sc     = a_q[31] ^ b_q[31];
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        e_raw  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (acc_q[47]) begin
            mant   = acc_q[46:24];
            guard  = acc_q[23];
            sticky = |acc_q[22:0];
            e_n    = e_raw + 10'sd1;
        end else begin
            mant   = acc_q[45:23];
            guard  = acc_q[22];
            sticky = |acc_q[21:0];
            e_n    = e_raw;
        end
        mant_r = {1'b0, mant} + {23'h0, guard & (sticky | mant[0])};
        // carry out of the mantissa leaves mant_r[22:0] == 0, i.e. 1.0 * 2^(e+1)
        e_fin  = mant_r[23] ? e_n + 10'sd1 : e_n;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res = 32'h7FC00000;
        else if (a_inf || b_inf)
            res = {sc, 8'hFF, 23'h0};
        else if (a_zero || b_zero)
            res = {sc, 31'h0};
        else if (e_fin >= 10'sd255)
            res = {sc, 8'hFF, 23'h0};
        else if (e_fin <= 10'sd0)
            res = {sc, 31'h0};
        else
            res = {sc, e_fin[7:0], mant_r[22:0]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        res_vld_d = 1'b0;
        case (state_q)
            IDLE: if (arg_vld) begin
                a_d      = a;
                b_d      = b;
                mcand_d  = {24'h0, 1'b1, a[22:0]};
                mplier_d = {1'b1, b[22:0]};
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = MUL;
            end
            MUL: begin
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER - 1)) state_d = RND;
            end
            RND: begin
                c_d       = res;
                res_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign res_vld = res_vld_q;
    assign c       = c_q;
endmodule

// File: tb/tb_fp_mul.sv
// Bench for fp_mul: BPC=1 and BPC=4 instances, table-driven vectors with a
// per-instance scoreboard checking result value and capture-to-result latency.
module tb_fp_mul;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld1 = 1'b0, vld4 = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy1, busy4, rv1, rv4;
    logic [31:0] c1, c4;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct { logic [31:0] c; int cap; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] c; } vec_t;
    exp_t q1[$];
    exp_t q4[$];
    vec_t vecs[9];

    fp_mul #(.BPC(1)) dut1 (.clk(clk), .rst(rst), .arg_vld(vld1), .busy(busy1),
                            .res_vld(rv1), .a(a), .b(b), .c(c1));
    fp_mul #(.BPC(4)) dut4 (.clk(clk), .rst(rst), .arg_vld(vld4), .busy(busy4),
                            .res_vld(rv4), .a(a), .b(b), .c(c4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_res(input int s, input logic [31:0] cc, input logic bz);
        exp_t e;
        int   lat;
        lat = (s == 0) ? 25 : 7;
        tests++;
        if ((s == 0 && q1.size() == 0) || (s == 1 && q4.size() == 0)) begin
            fails++;
            $display("FAIL unexpected_res_vld bpc_sel=%0d c=%h", s, cc);
        end else begin
            e = (s == 0) ? q1.pop_front() : q4.pop_front();
            if (cc !== e.c || (cyc - e.cap) != lat || bz !== 1'b0) begin
                fails++;
                $display("FAIL result bpc_sel=%0d got c=%h lat=%0d busy=%b want c=%h lat=%0d busy=0",
                         s, cc, cyc - e.cap, bz, e.c, lat);
            end
        end
    endtask

    always @(negedge clk) if (rst && rv1) check_res(0, c1, busy1);
    always @(negedge clk) if (rst && rv4) check_res(1, c4, busy4);

    task automatic push(input int s, input logic [31:0] e, input int cap);
        exp_t x;
        x.c = e;
        x.cap = cap;
        if (s == 0) q1.push_back(x); else q4.push_back(x);
    endtask

    task automatic wait_drain(input int s);
        for (int k = 0; k < 100; k++) begin
            if ((s == 0 ? q1.size() : q4.size()) == 0) break;
            @(posedge clk);
        end
        #1;
        if ((s == 0 ? q1.size() : q4.size()) != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout bpc_sel=%0d pending=%0d want 0", s,
                     (s == 0) ? q1.size() : q4.size());
            if (s == 0) q1.delete(); else q4.delete();
        end
    endtask

    // called #1 after a posedge with the selected instance idle
    task automatic run_op(input int s, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] e);
        a = x;
        b = y;
        push(s, e, cyc + 1);
        if (s == 0) vld1 = 1'b1; else vld4 = 1'b1;
        @(posedge clk);
        #1;
        vld1 = 1'b0;
        vld4 = 1'b0;
        a = $urandom;
        b = $urandom;
        wait_drain(s);
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        int cap1;
        vecs[0] = '{32'h40400000, 32'h40A00000, 32'h41700000};
        vecs[1] = '{32'hC0000000, 32'h3F000000, 32'hBF800000};
        vecs[2] = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
        vecs[3] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002};
        vecs[4] = '{32'h7F000000, 32'h40000000, 32'h7F800000};
        vecs[5] = '{32'h00800000, 32'h00800000, 32'h00000000};
        vecs[6] = '{32'h80000000, 32'h3F800000, 32'h80000000};
        vecs[7] = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
        vecs[8] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000};

        repeat (3) @(posedge clk);
        #1;
        cmp("reset_busy1", {31'h0, busy1}, 32'h0);
        cmp("reset_rv1", {31'h0, rv1}, 32'h0);
        cmp("reset_c1", c1, 32'h0);
        cmp("reset_c4", c4, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 9; i++) run_op(s, vecs[i].a, vecs[i].b, vecs[i].c);
            run_op(s, 32'hFF800000, 32'h40000000, 32'hFF800000);
        end

        // back-to-back: arg_vld held high, second capture on the res_vld edge
        a = 32'hC0000000;
        b = 32'h3F000000;
        vld1 = 1'b1;
        cap1 = cyc + 1;
        push(0, 32'hBF800000, cap1);
        @(posedge clk);
        #1;
        a = 32'h3FC00000;
        b = 32'h3FC00000;
        push(0, 32'h40100000, cap1 + 26);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rv1) break;
        end
        @(posedge clk);
        #1;
        vld1 = 1'b0;
        wait_drain(0);

        // asynchronous reset at iteration 10, mid-cycle
        a = 32'h40400000;
        b = 32'h40A00000;
        vld1 = 1'b1;
        @(posedge clk);
        #1;
        vld1 = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        cmp("rst_busy1", {31'h0, busy1}, 32'h0);
        cmp("rst_rv1", {31'h0, rv1}, 32'h0);
        cmp("rst_c1", c1, 32'h0);
        cmp("rst_c4", c4, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        cmp("post_rst_idle_c1", c1, 32'h0);
        run_op(0, 32'h40400000, 32'h40A00000, 32'h41700000);
        run_op(1, 32'h40400000, 32'h40A00000, 32'h41700000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
